// File: rtl/aes_encrypt_core.sv
// Iterative AES forward cipher: one round per clock over a pre-expanded key schedule.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready plaintext + key schedule handshake (in_ready is combinational)
//   Message           128-bit plaintext, FIPS-197 byte 0 in Message[127:120]
//   keySchedule       round keys, round k at [128*k +: 128], round 0 lowest
//   cipher_valid/cipher_ready  ciphertext handshake
//   cipher            ciphertext, driven from the round state register
//   busy              high while rounds are being computed
module aes_encrypt_core #(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           Message,
  input  logic [128*(nr+1)-1:0]  keySchedule,
  output logic                   cipher_valid,
  input  logic                   cipher_ready,
  output logic [127:0]           cipher,
  output logic                   busy
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;
  // Final round index; never runs past what either the key length or the schedule supports.
  localparam int unsigned LAST_ROUND = (nr < nk + 6) ? nr : nk + 6;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BLOCK_W-1:0]   aes_q, aes_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 valid_q, valid_d;

  logic                 accept;
  logic                 last_round;
  logic [BLOCK_W-1:0]   round_key;
  logic [BLOCK_W-1:0]   sb_sr;
  logic [BLOCK_W-1:0]   mixed;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes fused with ShiftRows: byte (row r, col c) takes input column (c+r) mod 4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && cipher_ready);
  assign cipher       = aes_q;
  assign cipher_valid = valid_q;
  assign busy         = (state_q == ROUND);

  // Round datapath.
  assign round_key  = keySchedule[BLOCK_W*int'(round_q) +: BLOCK_W];
  assign sb_sr      = sub_shift(aes_q);
  assign mixed      = mix_columns(sb_sr);
  assign last_round = (round_q == ROUND_W'(LAST_ROUND));
  assign accept     = in_valid && in_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      aes_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      aes_q   <= aes_d;
      round_q <= round_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; an accept overrides the DONE->IDLE hand-off.
  always_comb begin
    state_d = state_q;
    aes_d   = aes_q;
    round_d = round_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: ;
      ROUND: begin
        if (last_round) begin
          aes_d   = sb_sr ^ round_key;
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          aes_d   = mixed ^ round_key;
          round_d = round_q + 1'b1;
        end
      end
      DONE: begin
        if (cipher_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      aes_d   = Message ^ keySchedule[BLOCK_W-1:0];
      round_d = ROUND_W'(1);
      valid_d = 1'b0;
      state_d = ROUND;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Testbench for aes_encrypt_core: FIPS-197 / SP800-38A known answers for AES-128 and AES-256,
// handshake timing, back-pressure, back-to-back blocks, asynchronous reset and ignored inputs.
module tb_aes_encrypt_core;

  localparam int unsigned KS10_W = 128 * 11;
  localparam int unsigned KS14_W = 128 * 15;

  logic              clk;
  logic              reset;
  logic              in_valid, in_ready, cipher_valid, cipher_ready, busy;
  logic [127:0]      Message, cipher;
  logic [KS10_W-1:0] ks10;

  logic              in_valid14, in_ready14, cipher_valid14, cipher_ready14, busy14;
  logic [127:0]      Message14, cipher14;
  logic [KS14_W-1:0] ks14;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [256];

  typedef struct {
    logic [127:0] msg;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  aes_encrypt_core #(.nk(4), .nr(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Message(Message), .keySchedule(ks10), .cipher_valid(cipher_valid),
    .cipher_ready(cipher_ready), .cipher(cipher), .busy(busy)
  );

  aes_encrypt_core #(.nk(8), .nr(14)) dut14 (
    .clk(clk), .reset(reset), .in_valid(in_valid14), .in_ready(in_ready14),
    .Message(Message14), .keySchedule(ks14), .cipher_valid(cipher_valid14),
    .cipher_ready(cipher_ready14), .cipher(cipher14), .busy(busy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = tb_xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      r1 = {inv[6:0], inv[7]};
      r2 = {r1[6:0], r1[7]};
      r3 = {r2[6:0], r2[7]};
      r4 = {r3[6:0], r3[7]};
      sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  // Key expansion; key is left-aligned in 256 bits, round k key lands at [128*k +: 128].
  function automatic logic [KS14_W-1:0] expand(input logic [255:0] key, input int kw);
    logic [31:0]       w [60];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [KS14_W-1:0] ks;
    int                rounds;
    rounds = kw + 6;
    rc = 8'h01;
    ks = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < kw; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = kw; i < 4*(rounds + 1); i++) begin
      t = w[i-1];
      if (i % kw == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end else if (kw > 6 && i % kw == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-kw] ^ t;
    end
    for (int k = 0; k <= rounds; k++) ks[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ks;
  endfunction

  function automatic logic [KS10_W-1:0] expand128(input logic [127:0] key);
    logic [KS14_W-1:0] full;
    full = expand({key, 128'h0}, 4);
    return full[KS10_W-1:0];
  endfunction

  // One block on the AES-128 core: accept, optional ignored poke during rounds,
  // latency check, optional back-pressure hold, then consume.
  task automatic do_block(input logic [127:0] msg, input logic [127:0] key, input logic [127:0] exp,
                          input string tag, input bit poke, input int hold);
    int  n;
    bit  ready_seen, busy_seen, hold_bad;
    @(negedge clk);
    Message = msg; ks10 = expand128(key); in_valid = 1'b1; cipher_ready = 1'b0;
    check({tag, "_in_ready_idle"}, 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    Message  = ~msg;
    n = 1; ready_seen = 1'b0; busy_seen = 1'b0;
    while (!cipher_valid && n < 30) begin
      if (in_ready) ready_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (poke && n == 3) begin
        in_valid = 1'b1;
        Message  = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
      end else if (poke && n == 4) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(11));
    check({tag, "_cipher"}, cipher, exp);
    check({tag, "_in_ready_low_in_round"}, 128'(ready_seen), 128'(0));
    check({tag, "_busy_in_round"}, 128'(busy_seen), 128'(1));
    if (hold > 0) begin
      hold_bad = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (cipher !== exp || cipher_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) hold_bad = 1'b1;
      end
      check({tag, "_hold_stable"}, 128'(hold_bad), 128'(0));
    end
    cipher_ready = 1'b1;
    @(negedge clk);
    cipher_ready = 1'b0;
    check({tag, "_valid_after_consume"}, 128'(cipher_valid), 128'(0));
    check({tag, "_in_ready_after_consume"}, 128'(in_ready), 128'(1));
    check({tag, "_cipher_kept"}, cipher, exp);
  endtask

  initial begin
    int  m, n;
    bit  flag;
    logic [KS14_W-1:0] tmp14;

    reset = 1'b0;
    in_valid = 1'b0; cipher_ready = 1'b0; Message = '0; ks10 = '0;
    in_valid14 = 1'b0; cipher_ready14 = 1'b0; Message14 = '0; ks14 = '0;

    build_sbox();
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97};
    vecs[3] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hf5d3d58503b9699de785895a96fdbaaf};

    repeat (2) @(negedge clk);
    check("rst_cipher", cipher, 128'h0);
    check("rst_valid", 128'(cipher_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst14_cipher", cipher14, 128'h0);
    check("rst14_in_ready", 128'(in_ready14), 128'(1));
    reset = 1'b1;

    // Known-answer vectors.
    for (int i = 0; i < 4; i++) begin
      do_block(vecs[i].msg, vecs[i].key, vecs[i].exp, $sformatf("vec%0d", i), 1'b0, 0);
    end

    // Back-pressure: cipher held for 5 cycles.
    do_block(vecs[1].msg, vecs[1].key, vecs[1].exp, "hold", 1'b0, 5);

    // Back-to-back: in_valid and cipher_ready held high, vector 0 then vector 1.
    @(negedge clk);
    Message = vecs[0].msg; ks10 = expand128(vecs[0].key); in_valid = 1'b1; cipher_ready = 1'b1;
    @(negedge clk);
    Message = vecs[1].msg;
    n = 1; flag = 1'b0;
    while (!cipher_valid && n < 30) begin
      if (in_ready) flag = 1'b1;
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 128'(n), 128'(11));
    check("b2b_first_cipher", cipher, vecs[0].exp);
    check("b2b_in_ready_first", 128'(flag), 128'(0));
    check("b2b_in_ready_done", 128'(in_ready), 128'(1));
    ks10 = expand128(vecs[1].key);
    m = 0; flag = 1'b0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        in_valid = 1'b0;
        check("b2b_valid_drop", 128'(cipher_valid), 128'(0));
        check("b2b_second_busy", 128'(busy), 128'(1));
      end
      if (!cipher_valid && in_ready) flag = 1'b1;
    end while (!cipher_valid && m < 30);
    check("b2b_spacing", 128'(m), 128'(11));
    check("b2b_second_cipher", cipher, vecs[1].exp);
    check("b2b_in_ready_second", 128'(flag), 128'(0));
    @(negedge clk);
    cipher_ready = 1'b0;
    check("b2b_end_valid", 128'(cipher_valid), 128'(0));

    // Asynchronous reset after round 5 of vector 0.
    @(negedge clk);
    Message = vecs[0].msg; ks10 = expand128(vecs[0].key); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1;
    check("async_rst_cipher", cipher, 128'h0);
    check("async_rst_valid", 128'(cipher_valid), 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    check("async_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    do_block(vecs[1].msg, vecs[1].key, vecs[1].exp, "post_rst", 1'b0, 0);

    // in_valid pulse during rounds is ignored.
    do_block(vecs[0].msg, vecs[0].key, vecs[0].exp, "poke", 1'b1, 0);

    // cipher_ready toggling in IDLE has no effect.
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cipher_ready = (k % 2 == 0);
      if (cipher_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || cipher !== vecs[0].exp) flag = 1'b1;
    end
    @(negedge clk);
    cipher_ready = 1'b0;
    if (cipher_valid !== 1'b0 || busy !== 1'b0 || cipher !== vecs[0].exp) flag = 1'b1;
    check("idle_ready_toggle", 128'(flag), 128'(0));

    // AES-256 build, FIPS-197 C.3.
    tmp14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    @(negedge clk);
    Message14 = 128'h00112233445566778899aabbccddeeff; ks14 = tmp14; in_valid14 = 1'b1;
    @(negedge clk);
    in_valid14 = 1'b0;
    Message14  = '0;
    n = 1;
    while (!cipher_valid14 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("aes256_latency", 128'(n), 128'(15));
    check("aes256_cipher", cipher14, 128'h8ea2b7ca516745bfeafc49904b496089);
    cipher_ready14 = 1'b1;
    @(negedge clk);
    cipher_ready14 = 1'b0;
    check("aes256_consume", 128'(cipher_valid14), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_core.md
Name: aes_encrypt_core

Overview:
Iterative AES forward cipher, one round per clock. It is the encryption counterpart of the codebase's iterative decrypt datapath. It consumes a plaintext block plus a pre-expanded key schedule and produces the ciphertext after nr round cycles. It has valid/ready handshakes on both sides, so it sits between the key-expansion block and the system datapath.

Parameters:
nk, 4, key length in 32-bit words (4/6/8 supported)
nr, 10, number of rounds (10/12/14, must match nk)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  plaintext and key schedule presented
in_ready  output  1  core can accept a block this cycle
Message  input  128  plaintext, bit 0 = MSB, FIPS-197 column-major byte order
keySchedule  input  128*(nr+1)  round keys; round k key at bits [128*k +:128], round 0 first
cipher_valid  output  1  cipher holds a finished block
cipher_ready  input  1  consumer takes cipher this cycle
cipher  output  128  ciphertext
busy  output  1  high while in ROUND state

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; round counter 0; state register 0.
  - cipher=0, cipher_valid=0, busy=0; in_ready=1 immediately.
  - Reset takes effect at any time, including mid-round or with a block pending in DONE. The aborted block is discarded and is never presented.
- States: IDLE, ROUND, DONE.
- in_ready = (IDLE) OR (DONE AND cipher_ready). Combinational.
- Accept = in_valid AND in_ready at a rising edge.
  - state register <= Message XOR keySchedule[0 +:128].
  - round counter <= 1; go to ROUND.
- ROUND, round counter r in 1..nr-1:
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key r).
  - r <= r+1.
  - Built from the codebase's existing forward primitives.
- ROUND, r = nr:
  - state <= AddRoundKey(ShiftRows(SubBytes(state)), key nr). No MixColumns.
  - Go to DONE; cipher_valid <= 1.
- Latency: cipher_valid rises exactly nr+1 rising edges after the accept edge (accept edge included). For nr=10 this is edge 11.
- DONE:
  - cipher and cipher_valid are held stable until cipher_ready=1.
  - cipher_ready=1 with no new accept: go to IDLE, cipher_valid <= 0. cipher keeps its last value.
  - cipher_ready=1 with in_valid=1 on the same edge: the new block is accepted, cipher_valid <= 0, go to ROUND. Back-to-back throughput is nr+1 cycles per block.
- cipher is driven directly from the state register.
  - While busy it shows intermediate round state; consumers qualify it with cipher_valid only.
- keySchedule must be held stable from the accept edge until cipher_valid rises. It is not latched. A change mid-block gives an undefined cipher and is a bench check, not a design requirement.
- Message is sampled only at the accept edge and may change afterwards.
- in_valid while busy is ignored (in_ready=0). No flag and no queueing.
- cipher_ready while not in DONE is ignored.
- Round counter is 4 bits and wide enough for nr=14. No wrap occurs because the counter is reset on every accept.

Test Plan:
1. FIPS-197 C.1: Message 00112233445566778899aabbccddeeff with the expanded key of 000102030405060708090a0b0c0d0e0f, nr=10.
   -> cipher_valid at edge 11 after accept; cipher = 69c4e0d86a7b0430d8cdb78070b4c55a.
2. FIPS-197 B: Message 3243f6a8885a308d313198a2e0370734 with the expanded key of 2b7e151628aed2a6abf7158809cf4f3c.
   -> cipher = 3925841d02dc09fbdc118597196a0b32.
   -> With cipher_ready held low for 5 cycles, cipher and cipher_valid stay constant.
3. Back-to-back: in_valid held high with cipher_ready=1, vectors 1 then 2.
   -> Second accept happens on the same edge the first cipher is consumed; outputs appear 11 cycles apart; in_ready=0 during ROUND.
4. Reset mid-operation: assert reset=0 after round 5 of vector 1, asynchronously between edges.
   -> cipher=0, cipher_valid=0, in_ready=1 before the next edge.
   -> After release, vector 2 completes correctly in 11 cycles.
5. Protocol: pulse in_valid with new data during ROUND.
   -> Ignored; the original block's cipher is unchanged.
   -> Toggle cipher_ready in IDLE: no state change.
6. nk=8/nr=14 build: FIPS-197 C.3 plaintext 00112233445566778899aabbccddeeff with the expanded 256-bit key 000102…1f.
   -> cipher = 8ea2b7ca516745bfeafc49904b496089 at edge 15 after accept.
